uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: line rate; DIV = CLK_HZ/BAUD, truncated (217 at defaults).
REQ-003 SHALL have parameter DEPTH, default 16: FIFO entries, power of two, 2..256.
REQ-004 SHALL have port sys_clk_i, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx_i, input, 1: asynchronous serial line from the SoC UART TX pad; idles high.
REQ-007 SHALL have port data_o, output, 8: FIFO head byte.
REQ-008 SHALL have port valid_o, output, 1: FIFO non-empty.
REQ-009 SHALL have port ready_i, input, 1: consumer pop; a byte is popped when valid_o and ready_i are both high.
REQ-010 SHALL have port count_o, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-011 SHALL have port overrun_o, output, 1: sticky flag, set when a byte is dropped because the FIFO is full.
REQ-012 SHALL have port frame_err_o, output, 1: sticky flag, set on a bad stop bit.
REQ-013 SHALL have port parity_err_o, output, 1: sticky flag, set on a parity mismatch.
REQ-014 SHALL have port clr_i, input, 1: synchronous clear of all sticky flags.

Function
REQ-015 SHALL pass rx_i through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE: a synchronized 1->0 transition SHALL move to START and load the bit counter with DIV/2-1.
REQ-017 START: on counter expiry, line=0 SHALL move to DATA with counter DIV-1; line=1 (glitch) SHALL return to IDLE with no flag set.
REQ-018 DATA: SHALL sample 8 bits LSB first, one sample per DIV cycles; after bit 7 SHALL go to PARITY if enabled, else STOP.
REQ-019 STOP: on sample, line=1 SHALL push the byte; line=0 SHALL drop the byte, set frame_err_o, and wait for line=1 before entering IDLE.
REQ-020 The push SHALL occur in the cycle after the stop-bit sample; valid_o SHALL rise one cycle after the push when the FIFO was empty.
REQ-021 A push while full with no same-cycle pop SHALL drop the new byte and set overrun_o; FIFO contents SHALL be unchanged.
REQ-022 A push and pop in the same cycle while full SHALL both succeed; count_o SHALL be unchanged and no overrun SHALL occur.
REQ-023 A push and pop in the same cycle while empty SHALL perform only the push; valid_o SHALL be low that cycle.
REQ-024 Pointers SHALL wrap modulo DEPTH; count_o SHALL range 0..DEPTH.
REQ-025 data_o SHALL be registered and stable while valid_o is high and ready_i is low.
REQ-026 A flag set event and clr_i in the same cycle SHALL leave the flag set.

Reset
REQ-027 During reset: FSM=IDLE, synchronizer flops=1, FIFO empty, count_o=0, valid_o=0, data_o=0, all sticky flags=0.
REQ-028 Reset mid-frame SHALL abort the frame; after release, reception SHALL resume only on the next falling edge.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample an even-parity bit after bit 7.
- A mismatch SHALL set parity_err_o and drop the byte; the stop bit SHALL still be checked.
REQ-030 Without UART_RX_PARITY_EN, PARITY SHALL be unreachable and parity_err_o SHALL be tied to 0.

Verification
REQ-031 Send 0x55 at 115200 with ready_i=1. Required: data_o=0x55 with valid_o high for 1 cycle; all flags 0.
REQ-032 Send 17 bytes 0x00..0x10 with ready_i=0 and DEPTH=16. Required: count_o=16, overrun_o=1; popped order 0x00..0x0F.
REQ-033 Send 0xA5 with stop bit=0. Required: frame_err_o=1, count_o=0; a following 0x3C is received correctly.
REQ-034 Drive a 40-cycle low glitch on rx_i. Required: FSM returns to IDLE, count_o=0, no flags set.
REQ-035 With UART_RX_PARITY_EN, send 0x07 with parity bit=0. Required: parity_err_o=1, byte dropped; pulsing clr_i for 1 cycle clears the flag.
REQ-036 Assert rst_n_i low during bit 4 of 0x81, then release and send 0x42. Required: only 0x42 is received.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, 1 stop bit) feeding a power-of-two byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_fifo #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                       sys_clk_i,
  input  logic                       rst_n_i,
  input  logic                       rx_i,
  output logic [7:0]                 data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overrun_o,
  output logic                       frame_err_o,
  output logic                       parity_err_o,
  input  logic                       clr_i
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(DIV + 1);

  localparam logic [TW-1:0] CNT_HALF = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] CNT_FULL = TW'(DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    settle_q;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic          bad_q, bad_d;
  logic          push_q, push_d;
  logic          ferr_set, perr_set;
  logic          fall, tick, rx;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d, remain;
  logic [7:0]    data_q, data_d;
  logic          full, do_pop, do_push, ovr_set;
  logic          ovr_q, ferr_q;

  assign rx   = rx_s2_q;
  assign tick = (cnt_q == '0);
  // The synchronizer resets to 1; a line held low through reset release
  // must not look like a start edge, so edges count only once it flushed.
  assign fall = (settle_q == 2'd3) & rx_prev_q & ~rx_s2_q;

  // Two-flop synchronizer plus edge-detect history.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      settle_q  <= 2'd0;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // Frame decoder: next state, bit timing and byte assembly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    brk_d    = brk_q;
    bad_d    = bad_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx) begin
          state_d = S_DATA;
          cnt_d   = CNT_FULL;
          bit_d   = 3'd0;
          bad_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d   = CNT_FULL;
          state_d = S_STOP;
          if (rx != ^shift_q) begin
            bad_d    = 1'b1;
            perr_set = 1'b1;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_STOP: begin
        if (brk_q) begin
          if (rx) begin
            brk_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx) begin
          push_d  = ~bad_q;
          state_d = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          brk_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame decoder state registers.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      brk_q   <= 1'b0;
      bad_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
      bad_q   <= bad_d;
      push_q  <= push_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = valid_o & ready_i;
  assign do_push = push_q & (~full | do_pop);
  assign ovr_set = push_q & full & ~do_pop;
  assign remain  = count_q - CW'(do_pop);

  // FIFO bookkeeping and the registered head byte.
  always_comb begin
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(do_push);
    count_d = remain + CW'(do_push);
    data_d  = data_q;
    if (count_d != '0) begin
      data_d = (remain == '0) ? shift_q : mem[rd_d];
    end
  end

  // Storage array; contents are qualified by count, so no reset.
  always_ff @(posedge sys_clk_i) begin
    if (do_push) mem[wr_q] <= shift_q;
  end

  // FIFO pointers, occupancy, head byte and sticky flags.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      data_q  <= 8'h00;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      data_q  <= data_d;
      ovr_q   <= (ovr_q & ~clr_i) | ovr_set;
      ferr_q  <= (ferr_q & ~clr_i) | ferr_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;

  // Sticky parity error.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) perr_q <= 1'b0;
    else          perr_q <= (perr_q & ~clr_i) | perr_set;
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign data_o      = data_q;
  assign count_o     = count_q;
  assign overrun_o   = ovr_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames, monitor-side checks.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 25000000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic [7:0]    data_o;
  logic          valid_o;
  logic          ready;
  logic [CW-1:0] count_o;
  logic          overrun_o;
  logic          frame_err_o;
  logic          parity_err_o;
  logic          clr;

  int n_chk  = 0;
  int n_pass = 0;
  int vhigh  = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .sys_clk_i    (clk),
    .rst_n_i      (rst_n),
    .rx_i         (rx),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready),
    .count_o      (count_o),
    .overrun_o    (overrun_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .clr_i        (clr)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                  name, act, act, req, req);
  endtask

  // Monitor: every accepted byte is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && valid_o) vhigh++;
    if (rst_n && valid_o && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", int'(data_o), -1);
      end else begin
        check("pop_data", int'(data_o), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_bit,
                      input bit par_ok);
    rx = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(DIV);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ ~par_ok;
    cyc(DIV);
`else
    if (!par_ok) rx = 1'b1;
`endif
    rx = stop_bit;
    cyc(DIV);
    rx = 1'b1;
    cyc(2 * DIV);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(2);
  endtask

  initial begin
    rx    = 1'b1;
    ready = 1'b1;
    clr   = 1'b0;
    rst_n = 1'b0;
    cyc(5);
    check("rst_count", int'(count_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_ovr", int'(overrun_o), 0);
    check("rst_ferr", int'(frame_err_o), 0);
    check("rst_perr", int'(parity_err_o), 0);
    rst_n = 1'b1;
    cyc(10);

    // Single byte, consumer always ready.
    vhigh = 0;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, 1'b1);
    check("b55_drained", exp_q.size(), 0);
    check("b55_valid_cycles", vhigh, 1);
    check("b55_ovr", int'(overrun_o), 0);
    check("b55_ferr", int'(frame_err_o), 0);
    check("b55_perr", int'(parity_err_o), 0);

    // Fill past capacity with consumer stalled.
    ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(i));
      send(8'(i), 1'b1, 1'b1);
    end
    check("full_count", int'(count_o), DEPTH);
    check("full_ovr", int'(overrun_o), 1);
    check("full_ferr", int'(frame_err_o), 0);
    check("full_head", int'(data_o), 0);
    ready = 1'b1;
    cyc(40);
    check("drain_count", int'(count_o), 0);
    check("drain_sb", exp_q.size(), 0);
    pulse_clr();
    check("ovr_cleared", int'(overrun_o), 0);

    // Bad stop bit, then a clean frame.
    send(8'hA5, 1'b0, 1'b1);
    check("ferr_set", int'(frame_err_o), 1);
    check("ferr_count", int'(count_o), 0);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b1);
    check("b3c_drained", exp_q.size(), 0);
    check("ferr_sticky", int'(frame_err_o), 1);
    pulse_clr();
    check("ferr_cleared", int'(frame_err_o), 0);

    // Short low glitch must be rejected silently.
    rx = 1'b0;
    cyc(40);
    rx = 1'b1;
    cyc(300);
    check("glitch_count", int'(count_o), 0);
    check("glitch_ferr", int'(frame_err_o), 0);
    check("glitch_ovr", int'(overrun_o), 0);
    check("glitch_perr", int'(parity_err_o), 0);
    exp_q.push_back(8'h96);
    send(8'h96, 1'b1, 1'b1);
    check("post_glitch_sb", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    check("perr_set", int'(parity_err_o), 1);
    check("perr_count", int'(count_o), 0);
    check("perr_ferr", int'(frame_err_o), 0);
    pulse_clr();
    check("perr_cleared", int'(parity_err_o), 0);
`endif

    // Reset in the middle of bit 4 of 0x81.
    rx = 1'b0;
    cyc(DIV);
    rx = 1'b1;
    cyc(DIV);
    rx = 1'b0;
    cyc(3 * DIV);
    cyc(DIV / 2);
    rst_n = 1'b0;
    cyc(3);
    check("mid_rst_count", int'(count_o), 0);
    check("mid_rst_valid", int'(valid_o), 0);
    check("mid_rst_data", int'(data_o), 0);
    rst_n = 1'b1;
    cyc(DIV - DIV / 2 - 3);
    cyc(2 * DIV);
    rx = 1'b1;
    cyc(DIV);
`ifdef UART_RX_PARITY_EN
    rx = 1'b0;
    cyc(DIV);
`endif
    rx = 1'b1;
    cyc(3 * DIV);
    check("post_rst_count", int'(count_o), 0);
    exp_q.push_back(8'h42);
    send(8'h42, 1'b1, 1'b1);
    check("b42_drained", exp_q.size(), 0);
    check("b42_count", int'(count_o), 0);
    check("final_ferr", int'(frame_err_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
